// File: rtl/mines_pkg.sv
// Shared types and constants for the 4x4 mines game: state codes, board
// geometry and the mine-count clamp applied when a new game starts.
package mines_pkg;

    localparam int BOARD_TILES = 16;
    localparam int IDX_W       = $clog2(BOARD_TILES);
    localparam int CNT_W       = IDX_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLACE  = 3'd1,
        S_PLAY   = 3'd2,
        S_CHECK  = 3'd3,
        S_LOST   = 3'd4,
        S_WON    = 3'd5,
        S_CASHED = 3'd6
    } state_t;

    // A game needs at least one mine and at least one safe tile.
    function automatic logic [IDX_W-1:0] clamp_mines(input logic [IDX_W-1:0] req);
        logic [CNT_W-1:0] wide;
        wide = {1'b0, req};
        if (wide == '0)
            return IDX_W'(1);
        if (wide > CNT_W'(BOARD_TILES - 1))
            return IDX_W'(BOARD_TILES - 1);
        return req;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Active-low key conditioner: 2-FF synchroniser, stable-level debounce counter
// and a one-cycle event on each debounced press (1 -> 0 transition).
module key_debouncer #(
    parameter int STABLE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic evt
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            evt   <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                // level differs from sync2 here, so level==1 means a press
                evt   <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mines_game_controller.sv
// Game-flow sequencer: conditions the keys, kicks mine placement, tracks
// revealed tiles and decides win / loss / cash-out. All outputs registered.
module mines_game_controller
    import mines_pkg::*;
#(
    parameter int NUM_TILES       = BOARD_TILES,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int PLACE_TIMEOUT   = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_n,
    input  logic                 reveal_n,
    input  logic                 cash_out,
    input  logic [IDX_W-1:0]     mine_count,
    input  logic [IDX_W-1:0]     cursor,
    input  logic [NUM_TILES-1:0] mine_map,
    input  logic                 placement_done,
    output logic                 place_start,
    output logic                 tile_reveal,
    output logic [NUM_TILES-1:0] revealed_map,
    output logic                 game_over,
    output logic                 game_won,
    output logic                 cashed,
    output logic                 place_err,
    output logic [2:0]           state_o
);

    localparam int TW = $clog2(PLACE_TIMEOUT + 1);

    logic start_evt;
    logic reveal_evt;
    logic cash_s1;
    logic cash_s2;

    key_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (clk),
        .rst   (rst),
        .key_n (start_n),
        .evt   (start_evt)
    );

    key_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_reveal_db (
        .clk   (clk),
        .rst   (rst),
        .key_n (reveal_n),
        .evt   (reveal_evt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cash_s1 <= 1'b0;
            cash_s2 <= 1'b0;
        end else begin
            cash_s1 <= cash_out;
            cash_s2 <= cash_s1;
        end
    end

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     mines_q, mines_d;
    logic [CNT_W-1:0]     safe_q, safe_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_TILES-1:0] revealed_d;
    logic                 place_start_d, tile_reveal_d;
    logic                 game_over_d, game_won_d, cashed_d, place_err_d;
    logic [CNT_W-1:0]     target;
    logic [CNT_W-1:0]     safe_inc;

    assign target   = CNT_W'(NUM_TILES) - {1'b0, mines_q};
    assign safe_inc = safe_q + 1'b1;
    assign state_o  = state_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mines_d       = mines_q;
        safe_d        = safe_q;
        timer_d       = timer_q;
        revealed_d    = revealed_map;
        place_start_d = 1'b0;
        tile_reveal_d = 1'b0;
        game_over_d   = game_over;
        game_won_d    = game_won;
        cashed_d      = cashed;
        place_err_d   = place_err;

        unique case (state_q)
            S_IDLE, S_LOST, S_WON, S_CASHED: begin
                if (start_evt) begin
                    state_d       = S_PLACE;
                    place_start_d = 1'b1;
                    mines_d       = clamp_mines(mine_count);
                    revealed_d    = '0;
                    safe_d        = '0;
                    timer_d       = '0;
                    game_over_d   = 1'b0;
                    game_won_d    = 1'b0;
                    cashed_d      = 1'b0;
                    place_err_d   = 1'b0;
                end
            end
            S_PLACE: begin
                if (placement_done) begin
                    state_d = S_PLAY;
                end else if (timer_q == TW'(PLACE_TIMEOUT - 1)) begin
                    state_d     = S_IDLE;
                    place_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_PLAY: begin
                // A reveal of a fresh tile takes priority; cash is seen again next cycle.
                if (reveal_evt && !revealed_map[cursor]) begin
                    state_d = S_CHECK;
                    idx_d   = cursor;
                end else if (cash_s2 && (safe_q != '0)) begin
                    state_d  = S_CASHED;
                    cashed_d = 1'b1;
                end
            end
            S_CHECK: begin
                revealed_d[idx_q] = 1'b1;
                if (mine_map[idx_q]) begin
                    state_d     = S_LOST;
                    game_over_d = 1'b1;
                end else begin
                    tile_reveal_d = 1'b1;
                    safe_d        = safe_inc;
                    if (safe_inc == target) begin
                        state_d    = S_WON;
                        game_won_d = 1'b1;
                    end else begin
                        state_d = S_PLAY;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            mines_q      <= '0;
            safe_q       <= '0;
            timer_q      <= '0;
            revealed_map <= '0;
            place_start  <= 1'b0;
            tile_reveal  <= 1'b0;
            game_over    <= 1'b0;
            game_won     <= 1'b0;
            cashed       <= 1'b0;
            place_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mines_q      <= mines_d;
            safe_q       <= safe_d;
            timer_q      <= timer_d;
            revealed_map <= revealed_d;
            place_start  <= place_start_d;
            tile_reveal  <= tile_reveal_d;
            game_over    <= game_over_d;
            game_won     <= game_won_d;
            cashed       <= cashed_d;
            place_err    <= place_err_d;
        end
    end

endmodule

// File: tb/tb_mines_game_controller.sv
// Self-checking bench for mines_game_controller with short debounce/timeout;
// a small game model pushes expectations that are popped once the DUT settles.
module tb_mines_game_controller;

    localparam int DB = 4;
    localparam int PT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_n = 1'b1;
    logic        reveal_n = 1'b1;
    logic        cash_out = 1'b0;
    logic [3:0]  mine_count = '0;
    logic [3:0]  cursor = '0;
    logic [15:0] mine_map = '0;
    logic        placement_done = 1'b0;
    logic        place_start;
    logic        tile_reveal;
    logic [15:0] revealed_map;
    logic        game_over;
    logic        game_won;
    logic        cashed;
    logic        place_err;
    logic [2:0]  state_o;

    mines_game_controller #(
        .NUM_TILES       (16),
        .DEBOUNCE_CYCLES (DB),
        .PLACE_TIMEOUT   (PT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_n        (start_n),
        .reveal_n       (reveal_n),
        .cash_out       (cash_out),
        .mine_count     (mine_count),
        .cursor         (cursor),
        .mine_map       (mine_map),
        .placement_done (placement_done),
        .place_start    (place_start),
        .tile_reveal    (tile_reveal),
        .revealed_map   (revealed_map),
        .game_over      (game_over),
        .game_won       (game_won),
        .cashed         (cashed),
        .place_err      (place_err),
        .state_o        (state_o)
    );

    // clock / pulse counters
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_tr  = 0;
    int n_ps  = 0;

    always @(negedge clk) begin
        if (tile_reveal === 1'b1) n_tr++;
        if (place_start === 1'b1) n_ps++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
        $fatal(1, "watchdog");
    end

    // scoreboard
    logic [31:0] exp_q[$];

    // game model
    int          m_state = 0;
    logic [15:0] m_rev = '0;
    logic [15:0] m_mines = '0;
    int          m_safe = 0;
    int          m_target = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] got);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
        check(tag, got, e);
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
        int n = 0;
        while (state_o !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {29'd0, state_o}, {29'd0, code});
    endtask

    task automatic new_game(input logic [3:0] mc, input logic [15:0] map);
        int p0;
        mine_count = mc;
        mine_map   = map;
        p0         = n_ps;
        m_mines    = map;
        m_rev      = '0;
        m_safe     = 0;
        m_target   = 16 - ((mc == 4'd0) ? 1 : int'(mc));
        m_state    = 2;
        sb_push(32'd1);
        sb_push(32'd0);
        sb_push(32'd0);
        sb_push(32'd0);
        sb_push(32'd0);
        sb_push(32'd0);
        @(negedge clk);
        start_n = 1'b0;
        wait_state(3'd1, 20, "enter_place");
        start_n = 1'b1;
        tick(5);
        placement_done = 1'b1;
        tick(1);
        placement_done = 1'b0;
        wait_state(3'd2, 4, "enter_play");
        sb_pop("place_pulses", n_ps - p0);
        sb_pop("map_cleared", {16'd0, revealed_map});
        sb_pop("over_cleared", {31'd0, game_over});
        sb_pop("won_cleared", {31'd0, game_won});
        sb_pop("cashed_cleared", {31'd0, cashed});
        sb_pop("err_cleared", {31'd0, place_err});
        tick(DB + 4);
    endtask

    task automatic do_reveal(input int tile);
        int t0;
        int ep = 0;
        if (m_state == 2 && !m_rev[tile]) begin
            m_rev[tile] = 1'b1;
            if (m_mines[tile]) begin
                m_state = 4;
            end else begin
                m_safe++;
                ep = 1;
                if (m_safe == m_target) m_state = 5;
            end
        end
        sb_push(32'(m_state));
        sb_push({16'd0, m_rev});
        sb_push(32'(ep));
        sb_push((m_state == 4) ? 32'd1 : 32'd0);
        sb_push((m_state == 5) ? 32'd1 : 32'd0);
        t0 = n_tr;
        cursor = tile[3:0];
        @(negedge clk);
        reveal_n = 1'b0;
        tick(DB + 8);
        reveal_n = 1'b1;
        tick(DB + 6);
        sb_pop("rv_state", {29'd0, state_o});
        sb_pop("rv_map", {16'd0, revealed_map});
        sb_pop("rv_pulses", n_tr - t0);
        sb_pop("rv_over", {31'd0, game_over});
        sb_pop("rv_won", {31'd0, game_won});
    endtask

    task automatic do_cash();
        if (m_state == 2 && m_safe > 0) m_state = 6;
        sb_push(32'(m_state));
        sb_push((m_state == 6) ? 32'd1 : 32'd0);
        cash_out = 1'b1;
        tick(8);
        cash_out = 1'b0;
        tick(4);
        sb_pop("cash_state", {29'd0, state_o});
        sb_pop("cash_flag", {31'd0, cashed});
    endtask

    // stimulus
    initial begin
        int n;
        int t0;
        int p0;
        int glitch[6] = '{1, 2, 2, 1, 1, 2};

        // reset state
        repeat (3) sb_push(32'd0);
        repeat (5) sb_push(32'd0);
        tick(3);
        sb_pop("rst_state", {29'd0, state_o});
        sb_pop("rst_map", {16'd0, revealed_map});
        sb_pop("rst_place_start", {31'd0, place_start});
        sb_pop("rst_tile_reveal", {31'd0, tile_reveal});
        sb_pop("rst_over", {31'd0, game_over});
        sb_pop("rst_won", {31'd0, game_won});
        sb_pop("rst_cashed", {31'd0, cashed});
        sb_pop("rst_err", {31'd0, place_err});
        rst = 1'b1;
        tick(3);

        // 1+2: start, then win by revealing every safe tile
        new_game(4'd3, 16'h0007);
        for (int t = 3; t < 16; t++) do_reveal(t);
        sb_push(32'hFFF8);
        sb_pop("won_map", {16'd0, revealed_map});

        // 3: mine hit, then reveals ignored in LOST
        new_game(4'd3, 16'h0007);
        do_reveal(0);
        do_reveal(1);

        // 4: early cash ignored, double reveal, start ignored mid-game, cash
        new_game(4'd3, 16'h0007);
        do_cash();
        do_reveal(5);
        do_reveal(5);
        p0 = n_ps;
        sb_push(32'd2);
        sb_push(32'd0);
        @(negedge clk);
        start_n = 1'b0;
        tick(DB + 8);
        start_n = 1'b1;
        tick(DB + 6);
        sb_pop("start_in_play_state", {29'd0, state_o});
        sb_pop("start_in_play_pulse", n_ps - p0);
        do_cash();

        // 5: bouncing key then one long press; reveal and cash together
        new_game(4'd3, 16'h0007);
        t0 = n_tr;
        cursor = 4'd9;
        sb_push(32'd2);
        sb_push(32'd0);
        sb_push(32'd0);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            reveal_n = (i % 2 == 1);
            tick(glitch[i]);
        end
        reveal_n = 1'b1;
        tick(10);
        sb_pop("bounce_state", {29'd0, state_o});
        sb_pop("bounce_map", {16'd0, revealed_map});
        sb_pop("bounce_pulses", n_tr - t0);
        m_rev[10] = 1'b1;
        m_safe    = 1;
        sb_push({16'd0, m_rev});
        sb_push(32'd1);
        cursor = 4'd10;
        reveal_n = 1'b0;
        tick(DB + 8);
        cursor = 4'd11;
        tick(100 - (DB + 8));
        reveal_n = 1'b1;
        tick(DB + 6);
        sb_pop("hold_map", {16'd0, revealed_map});
        sb_pop("hold_pulses", n_tr - t0);

        t0 = n_tr;
        m_rev[12] = 1'b1;
        m_state   = 6;
        sb_push(32'd1);
        sb_push({16'd0, m_rev});
        sb_push(32'd6);
        sb_push(32'd1);
        cursor = 4'd12;
        @(negedge clk);
        reveal_n = 1'b0;
        tick(DB);
        cash_out = 1'b1;
        tick(DB + 10);
        reveal_n = 1'b1;
        cash_out = 1'b0;
        tick(DB + 6);
        sb_pop("both_pulses", n_tr - t0);
        sb_pop("both_map", {16'd0, revealed_map});
        sb_pop("both_state", {29'd0, state_o});
        sb_pop("both_cashed", {31'd0, cashed});

        // 6: placement never completes
        p0 = n_ps;
        mine_count = 4'd2;
        sb_push(32'(PT));
        sb_push(32'd0);
        sb_push(32'd1);
        sb_push(32'd1);
        @(negedge clk);
        start_n = 1'b0;
        wait_state(3'd1, 20, "t6_place");
        start_n = 1'b1;
        n = 0;
        while (state_o === 3'd1 && n < 4 * PT) begin
            tick(1);
            n++;
        end
        sb_pop("place_cycles", n);
        sb_pop("timeout_state", {29'd0, state_o});
        sb_pop("timeout_err", {31'd0, place_err});
        sb_pop("timeout_place_pulse", n_ps - p0);
        m_state = 0;
        tick(DB + 4);

        // clamp boundaries: 15 mines -> one safe tile; 0 mines -> 15 safe tiles
        new_game(4'd15, 16'hFFFE);
        do_reveal(0);
        new_game(4'd0, 16'h8000);
        for (int t = 0; t < 15; t++) do_reveal(t);

        // asynchronous reset mid-game
        new_game(4'd3, 16'h0007);
        do_reveal(4);
        repeat (8) sb_push(32'd0);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        sb_pop("arst_state", {29'd0, state_o});
        sb_pop("arst_map", {16'd0, revealed_map});
        sb_pop("arst_place_start", {31'd0, place_start});
        sb_pop("arst_tile_reveal", {31'd0, tile_reveal});
        sb_pop("arst_over", {31'd0, game_over});
        sb_pop("arst_won", {31'd0, game_won});
        sb_pop("arst_cashed", {31'd0, cashed});
        sb_pop("arst_err", {31'd0, place_err});
        tick(2);
        rst = 1'b1;
        tick(2);

        // report
        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
